// File: rtl/vga_pixel_clip_fifo.sv
// vga_pixel_clip_fifo: clips off-screen pixels, queues the rest and drains one per cycle to the VGA adapter.
// Optional PIXEL_CLIP_STATS_EN adds saturating kept/dropped pixel counters.
module vga_pixel_clip_fifo #(
    parameter int DEPTH    = 8,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [8:0] in_x,
    input  logic [7:0] in_y,
    input  logic [2:0] in_colour,
    input  logic       drain_en,
    input  logic       flush_req,
    output logic       flush_done,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot
`ifdef PIXEL_CLIP_STATS_EN
    ,
    output logic [15:0] kept_count,
    output logic [15:0] drop_count
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [1:0] RUN = 2'd0, FLUSH = 2'd1, DONE = 2'd2;

    logic [1:0]    state;
    logic          live;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [17:0]   mem [DEPTH];
    logic          full, empty, accept, in_frame, push, pop;

    assign full       = count == (AW+1)'(DEPTH);
    assign empty      = count == '0;
    assign in_ready   = live && !full && state == RUN;
    assign accept     = in_valid && in_ready;
    // sign bits reject negatives, so the upper-bound compares can use the magnitude bits
    assign in_frame   = !in_x[8] && !in_y[7] && int'(in_x[7:0]) < SCREEN_W && int'(in_y[6:0]) < SCREEN_H;
    assign push       = accept && in_frame;
    assign pop        = !empty && drain_en;
    assign flush_done = state == DONE;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {in_x[7:0], in_y[6:0], in_colour};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            live       <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            vga_plot   <= 1'b0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
        end else begin
            live     <= 1'b1;
            vga_plot <= pop;
            count    <= count + (AW+1)'(push) - (AW+1)'(pop);
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                {vga_x, vga_y, vga_colour} <= mem[rd_ptr];
            end
            // an empty FIFO with no incoming pixel skips FLUSH and reports at once
            state <= state == RUN   ? (flush_req ? ((empty && !push) ? DONE : FLUSH) : RUN) :
                     state == FLUSH ? (empty ? DONE : FLUSH) : RUN;
        end
    end

`ifdef PIXEL_CLIP_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kept_count <= '0;
            drop_count <= '0;
        end else begin
            if (push && kept_count != 16'hFFFF) kept_count <= kept_count + 16'd1;
            if (accept && !in_frame && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_vga_pixel_clip_fifo.sv
// tb_vga_pixel_clip_fifo: directed tests against a queue-based model of the clip FIFO.
// Define PIXEL_CLIP_STATS_EN to also check the statistics counters.
module tb_vga_pixel_clip_fifo;
    localparam int DEPTH = 8;

    logic       clk = 0, rst_n = 1;
    logic       in_valid = 0, drain_en = 1, flush_req = 0;
    logic [8:0] in_x = 0;
    logic [7:0] in_y = 0;
    logic [2:0] in_colour = 0;
    logic       in_ready, flush_done, vga_plot;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
`ifdef PIXEL_CLIP_STATS_EN
    logic [15:0] kept_count, drop_count;
`endif

    vga_pixel_clip_fifo #(.DEPTH(DEPTH), .SCREEN_W(160), .SCREEN_H(120)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .in_colour(in_colour), .drain_en(drain_en),
        .flush_req(flush_req), .flush_done(flush_done), .vga_x(vga_x), .vga_y(vga_y),
        .vga_colour(vga_colour), .vga_plot(vga_plot)
`ifdef PIXEL_CLIP_STATS_EN
        , .kept_count(kept_count), .drop_count(drop_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, cyc = 0;
    logic [17:0] mq[$];
    bit          m_live = 0;
    int          m_mode = 0;
    bit          e_plot = 0;
    logic [7:0]  e_x = 0;
    logic [6:0]  e_y = 0;
    logic [2:0]  e_c = 0;
    int          m_kept = 0, m_drop = 0;
    logic [17:0] plog[$];
    int          plogt[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit m_ready();
        return m_live && mq.size() < DEPTH && m_mode == 0;
    endfunction

    // model: mode 0 run, 1 flushing, 2 reporting done
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            mq.delete();
            m_live = 0; m_mode = 0; e_plot = 0; e_x = 0; e_y = 0; e_c = 0; m_kept = 0; m_drop = 0;
        end else begin
            int xs, ys;
            bit acc, keep, was_empty;
            cyc++;
            xs = int'($signed(in_x));
            ys = int'($signed(in_y));
            acc = in_valid && m_ready();
            keep = xs >= 0 && xs < 160 && ys >= 0 && ys < 120;
            was_empty = mq.size() == 0;
            e_plot = !was_empty && drain_en;
            if (e_plot) {e_x, e_y, e_c} = mq.pop_front();
            if (acc && keep) mq.push_back({in_x[7:0], in_y[6:0], in_colour});
            if (acc && keep && m_kept < 65535) m_kept++;
            if (acc && !keep && m_drop < 65535) m_drop++;
            m_mode = m_mode == 1 ? (was_empty ? 2 : 1) : m_mode == 2 ? 0 :
                     (flush_req ? ((was_empty && !(acc && keep)) ? 2 : 1) : 0);
            m_live = 1;
        end
    end

    initial forever begin
        @(negedge clk);
        chk("in_ready", in_ready, m_ready());
        chk("vga_plot", vga_plot, e_plot);
        chk("flush_done", flush_done, m_mode == 2);
        chk("vga_x", vga_x, e_x);
        chk("vga_y", vga_y, e_y);
        chk("vga_colour", vga_colour, e_c);
`ifdef PIXEL_CLIP_STATS_EN
        chk("kept_count", kept_count, m_kept);
        chk("drop_count", drop_count, m_drop);
`endif
        if (vga_plot === 1'b1) begin
            plog.push_back({vga_x, vga_y, vga_colour});
            plogt.push_back(cyc);
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic push(input int x, input int y, input int c, output int t);
        bit ok;
        int b = 0;
        in_valid = 1; in_x = 9'(x); in_y = 8'(y); in_colour = 3'(c);
        do begin ok = in_ready; step(); b++; end while (!ok && b < 50);
        chk("push_accepted", ok, 1);
        in_valid = 0;
        t = cyc;
    endtask

    initial begin
        int t, t0, b;
`ifdef PIXEL_CLIP_STATS_EN
        int k0, d0;
`endif
        #1 rst_n = 0;
        step(2);
        chk("rst_ready", in_ready, 0);
        chk("rst_plot", vga_plot, 0);
        chk("rst_x", vga_x, 0);
        chk("rst_done", flush_done, 0);
        rst_n = 1;
        step();
        chk("ready_first_edge", in_ready, 1);

        plog.delete(); plogt.delete();
        push(10, 20, 3, t);
        step(5);
        chk("single_count", plog.size(), 1);
        if (plog.size() > 0) begin
            chk("single_pixel", plog[0], {8'd10, 7'd20, 3'd3});
            chk("single_latency", plogt[0] - t, 1);
        end

`ifdef PIXEL_CLIP_STATS_EN
        k0 = kept_count; d0 = drop_count;
`endif
        plog.delete(); plogt.delete();
        push(-1, 5, 1, t);
        push(160, 5, 2, t);
        push(5, 120, 4, t);
        push(159, 119, 5, t);
        step(5);
        chk("clip_count", plog.size(), 1);
        if (plog.size() > 0) chk("clip_pixel", plog[0], {8'd159, 7'd119, 3'd5});
`ifdef PIXEL_CLIP_STATS_EN
        chk("clip_drop", drop_count - d0, 3);
        chk("clip_kept", kept_count - k0, 1);
`endif

        plog.delete(); plogt.delete();
        drain_en = 0;
        for (int i = 0; i < 8; i++) push(i, 1, i, t);
        chk("bp_full_ready", in_ready, 0);
        step(2);
        chk("bp_stalled", plog.size(), 0);
        drain_en = 1;
        step(12);
        chk("bp_count", plog.size(), 8);
        if (plog.size() == 8)
            for (int i = 0; i < 8; i++) begin
                chk("bp_order", plog[i][17:10], i);
                chk("bp_gapless", plogt[i] - plogt[0], i);
            end
        chk("bp_ready_back", in_ready, 1);

        plog.delete(); plogt.delete();
        push(0, 2, 0, t0);
        for (int i = 1; i < 20; i++) push(i, 2, i, t);
        step(5);
        chk("wrap_count", plog.size(), 20);
        if (plog.size() == 20) begin
            chk("wrap_first_latency", plogt[0] - t0, 1);
            for (int i = 0; i < 20; i++) begin
                chk("wrap_order", plog[i][17:10], i);
                chk("wrap_gapless", plogt[i] - plogt[0], i);
            end
        end

        plog.delete(); plogt.delete();
        drain_en = 0;
        for (int i = 0; i < 5; i++) push(30 + i, 3, i, t);
        flush_req = 1;
        step();
        flush_req = 0;
        chk("flush_ready_low", in_ready, 0);
        drain_en = 1;
        b = 0;
        while (flush_done !== 1'b1 && b < 30) begin step(); b++; end
        chk("flush_seen", flush_done, 1);
        chk("flush_plots", plog.size(), 5);
        if (plog.size() == 5) chk("flush_after_last", cyc - plogt[4], 1);
        step();
        chk("flush_pulse_one", flush_done, 0);
        chk("flush_ready_back", in_ready, 1);

        flush_req = 1;
        step();
        flush_req = 0;
        chk("eflush_done", flush_done, 1);
        step();
        chk("eflush_pulse_one", flush_done, 0);

        drain_en = 0;
        for (int i = 0; i < 4; i++) push(50 + i, 4, i, t);
        drain_en = 1;
        step();
        chk("pre_rst_plot", vga_plot, 1);
        #1 rst_n = 0;
        #1;
        chk("async_rst_plot", vga_plot, 0);
        chk("async_rst_ready", in_ready, 0);
        step();
        rst_n = 1;
        plog.delete(); plogt.delete();
        chk("rel_ready_before_edge", in_ready, 0);
        step();
        chk("rel_ready_first_edge", in_ready, 1);
        step(10);
        chk("no_stale_plots", plog.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
